// File: rtl/butterfly_reorder_merge_pkg.sv
// butterfly_reorder_merge_pkg: lane/tag geometry and error-cause encoding shared by the reorder stage
package butterfly_reorder_merge_pkg;
   localparam int NETWORK_WIDTH_LOG2 = 3;
   localparam int N = 2 ** NETWORK_WIDTH_LOG2;
   localparam int W = 8;
   localparam int TAG_W = 4;
   localparam int DEPTH = 2 ** TAG_W;
   localparam int TAG_LSB = 0;
   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_UNALLOC  = 2'd1,
      ERR_REFILL   = 2'd2,
      ERR_DUP_LANE = 2'd3
   } err_cause_e;
endpackage

// File: rtl/butterfly_reorder_slot.sv
// butterfly_reorder_slot: one reorder entry (allocated/filled flags plus data register)
// ports: alloc_set marks the entry allocated, write_en/write_data fill it,
//        retire_clr frees it; allocated/filled/data expose the entry state.
module butterfly_reorder_slot #(
   parameter int W = butterfly_reorder_merge_pkg::W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         alloc_set,
   input  logic         write_en,
   input  logic [W-1:0] write_data,
   input  logic         retire_clr,
   output logic         allocated,
   output logic         filled,
   output logic [W-1:0] data
);
   import butterfly_reorder_merge_pkg::*;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         allocated <= 1'b0;
         filled    <= 1'b0;
         data      <= '0;
      end else begin
         allocated <= alloc_set || (allocated && !retire_clr);
         filled    <= write_en || (filled && !retire_clr);
         if (write_en) data <= write_data;
      end
   end
endmodule

// File: rtl/butterfly_reorder_merge.sv
// butterfly_reorder_merge: re-serialises unordered network lanes into tag-allocation order
// ports: alloc_valid/alloc_ready/alloc_tag hand out tags upstream; in_valid_vec/in_payload_vec
//        carry N lanes (tag in the low TAG_W bits), in_ready_vec never backpressures;
//        out_valid/out_payload/out_ready stream the head entry; err_sticky flags dropped beats.
module butterfly_reorder_merge #(
   parameter int NETWORK_WIDTH_LOG2 = butterfly_reorder_merge_pkg::NETWORK_WIDTH_LOG2,
   parameter int W = butterfly_reorder_merge_pkg::W,
   parameter int TAG_W = butterfly_reorder_merge_pkg::TAG_W
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                alloc_valid,
   output logic                                alloc_ready,
   output logic [TAG_W-1:0]                    alloc_tag,
   input  logic [(2**NETWORK_WIDTH_LOG2)-1:0]  in_valid_vec,
   input  logic [W*(2**NETWORK_WIDTH_LOG2)-1:0] in_payload_vec,
   output logic [(2**NETWORK_WIDTH_LOG2)-1:0]  in_ready_vec,
   output logic                                out_valid,
   output logic [W-1:0]                        out_payload,
   input  logic                                out_ready,
   output logic                                err_sticky
);
   import butterfly_reorder_merge_pkg::*;
   localparam int N = 2 ** NETWORK_WIDTH_LOG2;
   localparam int DEPTH = 2 ** TAG_W;
   logic [TAG_W-1:0] alloc_ptr, head_ptr, lane_tag;
   logic [TAG_W:0]   occupancy;
   logic [DEPTH-1:0] allocated, filled, alloc_set, write_en, retire_clr;
   logic [W-1:0]     write_data [DEPTH];
   logic [W-1:0]     data [DEPTH];
   logic             lane_err, do_alloc, do_retire;
   assign alloc_ready = occupancy != (TAG_W+1)'(DEPTH);
   assign alloc_tag   = alloc_ptr;
   assign out_valid   = filled[head_ptr];
   assign out_payload = data[head_ptr];
   assign do_alloc    = alloc_valid && alloc_ready;
   assign do_retire   = out_valid && out_ready;
   // Lanes are scanned low to high, so the first legal claimant of an entry wins
   // and any later lane aimed at the same entry counts as an error.
   always_comb begin
      write_en = '0;
      lane_err = 1'b0;
      lane_tag = '0;
      for (int e = 0; e < DEPTH; e++) write_data[e] = '0;
      for (int i = 0; i < N; i++) begin
         lane_tag = in_payload_vec[i*W + TAG_LSB +: TAG_W];
         if (in_valid_vec[i]) begin
            if (allocated[lane_tag] && !filled[lane_tag] && !write_en[lane_tag]) begin
               write_en[lane_tag]   = 1'b1;
               write_data[lane_tag] = in_payload_vec[i*W +: W];
            end else begin
               lane_err = 1'b1;
            end
         end
      end
   end
   for (genvar s = 0; s < DEPTH; s++) begin : g_slot
      assign alloc_set[s]  = do_alloc && alloc_ptr == TAG_W'(s);
      assign retire_clr[s] = do_retire && head_ptr == TAG_W'(s);
      butterfly_reorder_slot #(.W(W)) u_slot (
         .clk        (clk),
         .rst_n      (rst_n),
         .alloc_set  (alloc_set[s]),
         .write_en   (write_en[s]),
         .write_data (write_data[s]),
         .retire_clr (retire_clr[s]),
         .allocated  (allocated[s]),
         .filled     (filled[s]),
         .data       (data[s])
      );
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alloc_ptr    <= '0;
         head_ptr     <= '0;
         occupancy    <= '0;
         err_sticky   <= 1'b0;
         in_ready_vec <= '0;
      end else begin
         alloc_ptr    <= alloc_ptr + TAG_W'(do_alloc);
         head_ptr     <= head_ptr + TAG_W'(do_retire);
         occupancy    <= occupancy + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_retire);
         err_sticky   <= err_sticky || lane_err;
         in_ready_vec <= '1;
      end
   end
endmodule

// File: tb/tb_butterfly_reorder_merge.sv
// tb_butterfly_reorder_merge: scoreboard bench for the reorder/merge stage
module tb_butterfly_reorder_merge;
   logic        clk = 1'b0, rst_n = 1'b0, alloc_valid = 1'b0, out_ready = 1'b0;
   logic [7:0]  in_valid_vec = '0;
   logic [63:0] in_payload_vec = '0;
   logic        alloc_ready, out_valid, err_sticky;
   logic [3:0]  alloc_tag;
   logic [7:0]  in_ready_vec, out_payload;
   int          total = 0, bad = 0;
   logic [7:0]  pend [16];
   logic [7:0]  q [$];
   logic [3:0]  unw [$];
   int          m_occ = 0, n_alloc = 0, a, start;
   logic [3:0]  m_aptr = '0, seq = '0, t;
   logic [7:0]  bp;

   butterfly_reorder_merge dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .alloc_valid    (alloc_valid),
      .alloc_ready    (alloc_ready),
      .alloc_tag      (alloc_tag),
      .in_valid_vec   (in_valid_vec),
      .in_payload_vec (in_payload_vec),
      .in_ready_vec   (in_ready_vec),
      .out_valid      (out_valid),
      .out_payload    (out_payload),
      .out_ready      (out_ready),
      .err_sticky     (err_sticky)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      in_valid_vec = '0;
   endtask

   task automatic drive(int l, logic [7:0] p);
      in_valid_vec[l] = 1'b1;
      in_payload_vec[l*8 +: 8] = p;
   endtask

   // Model of allocation: each granted tag gets a unique payload, queued in grant order.
   always @(negedge clk) begin : mon
      logic hs;
      logic [7:0] p;
      if (rst_n) begin
         hs = alloc_valid && m_occ != 16;
         check("alloc_ready", {31'd0, alloc_ready}, {31'd0, m_occ != 16});
         if (hs) begin
            check("alloc_tag", {28'd0, alloc_tag}, {28'd0, m_aptr});
            p = {seq, m_aptr};
            pend[m_aptr] = p;
            q.push_back(p);
            unw.push_back(m_aptr);
            m_aptr++;
            seq++;
            n_alloc++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) check("extra_out", {24'd0, out_payload}, 32'hffff_ffff);
            else check("out_payload", {24'd0, out_payload}, {24'd0, q.pop_front()});
         end
         m_occ += (hs ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      end
   end

   initial begin
      #2;
      check("rst_alloc_ready", {31'd0, alloc_ready}, 1);
      check("rst_alloc_tag", {28'd0, alloc_tag}, 0);
      check("rst_in_ready", {24'd0, in_ready_vec}, 0);
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out_payload", {24'd0, out_payload}, 0);
      check("rst_err", {31'd0, err_sticky}, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("in_ready_on", {24'd0, in_ready_vec}, 32'hff);
      // in-order return on lanes 0..3 in one cycle
      out_ready = 1'b1;
      alloc_valid = 1'b1;
      repeat (4) tick();
      alloc_valid = 1'b0;
      for (int i = 0; i < 4; i++) drive(i, pend[unw.pop_front()]);
      tick();
      for (int k = 0; k < 4; k++) begin
         check("inorder_valid", {31'd0, out_valid}, 1);
         tick();
      end
      check("inorder_end", {31'd0, out_valid}, 0);
      // reverse arrival on lane 5
      alloc_valid = 1'b1;
      repeat (8) tick();
      alloc_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check("rev_wait", {31'd0, out_valid}, 0);
         drive(5, pend[unw.pop_back()]);
         tick();
      end
      for (int k = 0; k < 8; k++) begin
         check("rev_stream", {31'd0, out_valid}, 1);
         tick();
      end
      check("rev_end", {31'd0, out_valid}, 0);
      // fill all entries, then free one
      out_ready = 1'b0;
      alloc_valid = 1'b1;
      repeat (17) tick();
      alloc_valid = 1'b0;
      check("full_ready", {31'd0, alloc_ready}, 0);
      check("full_occ", {27'd0, dut.occupancy}, 16);
      for (int k = 0; k < 8; k++) drive(k, pend[unw.pop_front()]);
      tick();
      for (int k = 0; k < 8; k++) drive(k, pend[unw.pop_front()]);
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("wrap_ready", {31'd0, alloc_ready}, 1);
      check("wrap_tag", {28'd0, alloc_tag}, 12);
      // random streaming across the wrap
      start = n_alloc;
      for (int c = 0; c < 3000 && !(n_alloc - start >= 40 && q.size() == 0); c++) begin
         alloc_valid = (n_alloc - start) < 40;
         if (unw.size() > 0 && $urandom_range(1, 0) == 1) begin
            a = $urandom_range(7, 0);
            drive(a, pend[unw.pop_front()]);
            if (unw.size() > 0) drive(a ^ 1, pend[unw.pop_front()]);
         end
         out_ready = $urandom_range(3, 0) != 0;
         tick();
      end
      alloc_valid = 1'b0;
      out_ready = 1'b0;
      check("stream_allocs", n_alloc - start, 40);
      check("stream_drain", q.size(), 0);
      // backpressure hold, then alloc with retire
      alloc_valid = 1'b1;
      tick();
      alloc_valid = 1'b0;
      t = unw.pop_front();
      bp = pend[t];
      drive(3, bp);
      tick();
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", {31'd0, out_valid}, 1);
         check("bp_payload", {24'd0, out_payload}, {24'd0, bp});
         tick();
      end
      alloc_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      alloc_valid = 1'b0;
      out_ready = 1'b0;
      check("occ_same", {27'd0, dut.occupancy}, 1);
      drive(0, pend[unw.pop_front()]);
      tick();
      out_ready = 1'b1;
      repeat (2) tick();
      out_ready = 1'b0;
      check("err_clean", {31'd0, err_sticky}, 0);
      // duplicate tag on lanes 2 and 6
      alloc_valid = 1'b1;
      repeat (4) tick();
      alloc_valid = 1'b0;
      t = unw.pop_front();
      drive(2, pend[t]);
      drive(6, pend[t] ^ 8'hf0);
      tick();
      check("dup_err", {31'd0, err_sticky}, 1);
      check("dup_keep", {24'd0, out_payload}, {24'd0, pend[t]});
      for (int k = 0; k < 3; k++) drive(k, pend[unw.pop_front()]);
      tick();
      out_ready = 1'b1;
      repeat (6) tick();
      out_ready = 1'b0;
      check("dup_drain", q.size(), 0);
      // asynchronous reset with entries filled
      alloc_valid = 1'b1;
      repeat (5) tick();
      alloc_valid = 1'b0;
      for (int k = 0; k < 5; k++) drive(k, pend[unw.pop_front()]);
      tick();
      check("pre_rst_valid", {31'd0, out_valid}, 1);
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", {31'd0, out_valid}, 0);
      check("arst_alloc_ready", {31'd0, alloc_ready}, 1);
      check("arst_alloc_tag", {28'd0, alloc_tag}, 0);
      check("arst_err", {31'd0, err_sticky}, 0);
      check("arst_in_ready", {24'd0, in_ready_vec}, 0);
      q.delete();
      unw.delete();
      m_occ = 0;
      m_aptr = '0;
      tick();
      rst_n = 1'b1;
      tick();
      // write to an unallocated tag is dropped
      drive(4, 8'ha9);
      tick();
      check("unalloc_err", {31'd0, err_sticky}, 1);
      alloc_valid = 1'b1;
      repeat (10) tick();
      alloc_valid = 1'b0;
      for (int k = 0; k < 8; k++) drive(k, pend[unw.pop_front()]);
      tick();
      drive(0, pend[unw.pop_front()]);
      tick();
      out_ready = 1'b1;
      repeat (12) tick();
      check("unalloc_dropped", {31'd0, out_valid}, 0);
      check("unalloc_left", q.size(), 1);
      drive(0, pend[unw.pop_front()]);
      repeat (3) tick();
      out_ready = 1'b0;
      check("final_drain", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/butterfly_reorder_merge.md
# butterfly_reorder_merge

Downstream stage of the buffered butterfly network. Collects the N network output lanes, whose ordering across lanes is not preserved, and re-serialises them into a single stream in tag-allocation order. The block owns the tag allocator that upstream issue logic uses before injecting into the network. Each lane's payload carries its tag in the low TAG_W bits.

## Interface
- NETWORK_WIDTH_LOG2, 3: log2 of lane count; N = 2**NETWORK_WIDTH_LOG2.
- W, 8: full lane payload width, tag included; W > TAG_W.
- TAG_W, 4: tag width; DEPTH = 2**TAG_W reorder entries.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  upstream requests a tag.
- alloc_ready  out  1  an entry is free (occupancy < DEPTH).
- alloc_tag  out  TAG_W  tag granted on an alloc handshake.
- in_valid_vec  in  N  network output valid, one bit per lane.
- in_payload_vec  in  W*N  lane i at [i*W +: W]; tag at bits [i*W +: TAG_W].
- in_ready_vec  out  N  all ones out of reset.
- out_valid  out  1  head entry is filled.
- out_payload  out  W  head entry's data, tag included.
- out_ready  in  1  consumer accepts.
- err_sticky  out  1  protocol error seen since reset.

## Operation
- State:
  - alloc_ptr and head_ptr, TAG_W bits each, wrapping mod DEPTH.
  - occupancy, TAG_W+1 bits.
  - Per entry: allocated bit, filled bit, and W-bit data register.
- Alloc handshake (alloc_valid && alloc_ready):
  - alloc_tag = alloc_ptr.
  - Set allocated[alloc_ptr], then alloc_ptr++.
  - alloc_ready = (occupancy != DEPTH), combinational from registers.
- Lane write: lane i with in_valid_vec[i] targets entry t = its tag.
  - Legal if allocated[t] && !filled[t]: capture data, set filled[t].
  - Otherwise drop the beat and set err_sticky.
- Same tag on several lanes in one cycle: lowest-indexed lane writes; the others are dropped and set err_sticky.
- in_ready_vec is never deasserted out of reset. Space is reserved at allocation, so the block never backpressures the network.
- Retire (out_valid && out_ready):
  - Clear allocated[head_ptr] and filled[head_ptr].
  - head_ptr++.
- out_valid = filled[head_ptr]; out_payload = data[head_ptr].
- Occupancy update per cycle:
  - +1 on alloc, -1 on retire.
  - Both in the same cycle leaves it unchanged.
  - It never exceeds DEPTH and never underflows.
- Alloc into the entry being retired in the same cycle:
  - Only possible when occupancy == DEPTH and the entry is the head.
  - alloc_ready is 0 in that case, so it does not occur.
  - An alloc into a different entry proceeds in parallel with a retire.
- A lane write to head_ptr in the same cycle it is retired cannot occur: retire requires filled, and writing a filled entry is an error.
- err_sticky clears only on reset.

## Timing
- Reset (asynchronous, held while rst_n low):
  - All pointers 0, occupancy 0, all allocated/filled bits 0, data registers 0.
  - Output values: alloc_ready 1, alloc_tag 0, in_ready_vec 0 during reset and all ones after, out_valid 0, out_payload 0, err_sticky 0.
- Reset mid-operation discards every entry; in-flight network beats arriving after reset release are errors.
- Latency:
  - A lane write at edge t makes filled visible after t.
  - If that entry is the head, out_valid is 1 in cycle t+1.
- Throughput: one retire per cycle sustained; up to N writes per cycle.
- Handshakes:
  - out_valid and out_payload stay stable while out_valid && !out_ready.
  - alloc_tag is valid whenever alloc_ready is 1.
- No combinational path from in_valid_vec or in_payload_vec to any output.
- out_valid depends only on registers; out_ready does not affect out_valid in the same cycle.

## Structure
- Shared package holds:
  - Lane count N, DEPTH, and the tag field position (low TAG_W bits of the payload).
  - Error-cause encoding, so the debug path can later replace err_sticky with a cause register.
- Sub-module butterfly_reorder_slot: one entry's allocated/filled/data registers, with inputs alloc_set, write_en/write_data, retire_clr and outputs filled/data. DEPTH instances.
- The top level holds the pointers, occupancy, the lane-to-entry priority write decoder, and the head mux.

## Test plan
- In-order: allocate tags 0..3, one per cycle; lanes 0..3 return tags 0..3 in one cycle; out_ready=1 -> out_payload tags 0,1,2,3 on four consecutive cycles starting the cycle after the write.
- Reverse arrival: allocate 0..7; tags return 7,6,...,0 one per cycle on lane 5 -> out_valid stays 0 until tag 0 is written, then tags 0..7 stream on 8 consecutive cycles.
- Full/wrap: allocate DEPTH=16 tags -> alloc_ready=0. Retire one -> alloc_ready=1 next cycle and alloc_tag=0. Continue across wrap for 40 tags with no loss.
- Backpressure: head filled, out_ready=0 for 5 cycles -> out_valid and out_payload stable. Simultaneous alloc+retire -> occupancy unchanged.
- Errors:
  - Lanes 2 and 6 both carry tag 3 -> lane 2 data kept, err_sticky=1.
  - A write to an unallocated tag 9 -> dropped, err_sticky=1.
- Reset: assert rst_n=0 with 5 entries filled -> out_valid=0, alloc_ready=1, alloc_tag=0, err_sticky=0 immediately, without a clock edge.
